square_plotter: RTL and testbench
=================================

Name: square_plotter

Overview:
- Downstream raster stage between the 10-square lane sequencer and the VGA adapter.
- Accepts one square request per handshake: top-left (x,y) plus 3-bit colour.
- Expands each request into SIZE×SIZE single-pixel writes, one pixel per clock, row-major.
- Clips pixels that fall off-screen and pulses done when the square is finished, so the sequencer can advance to its next square.

Parameters:
- SIZE, 4, square edge length in pixels (2..8).
- SCREEN_W, 160, visible width; pixels with x ≥ SCREEN_W are suppressed.
- SCREEN_H, 120, visible height; pixels with y ≥ SCREEN_H are suppressed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present on in_x/in_y/in_colour.
- in_ready  out  1  block can accept a request this cycle.
- in_x  in  8  starting (left) x coordinate.
- in_y  in  7  starting (top) y coordinate.
- in_colour  in  3  RGB colour (000 = black/erase).
- out_x  out  8  pixel x to VGA adapter.
- out_y  out  7  pixel y to VGA adapter.
- out_colour  out  3  pixel colour to VGA adapter.
- out_plot  out  1  write-enable to VGA adapter.
- busy  out  1  high while a square is being rasterised.
- done  out  1  one-cycle pulse after the last pixel of a square.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high (port reset).
- Reset values: all outputs 0 except in_ready=1. State = IDLE, offsets = 0.
- States: IDLE, DRAW, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clk edge: latch in_x/in_y/in_colour into base registers, clear dx=dy=0, go to DRAW.
- DRAW:
  - in_ready=0, busy=1.
  - Each cycle, registered outputs are out_x=base_x+dx and out_y=base_y+dy. Sums use 9-bit/8-bit internal width and are then truncated.
  - out_colour = latched colour.
  - out_plot=1 only if the untruncated sum is < SCREEN_W and < SCREEN_H; otherwise out_plot=0 but the cycle is still consumed.
  - dx increments each cycle. At dx=SIZE-1, dx wraps to 0 and dy increments.
  - After the pixel at dx=dy=SIZE-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, out_plot=0, busy=0, in_ready=0.
  - Next state IDLE.
- Latency:
  - Handshake at edge N → first pixel visible with out_plot high in cycle N+1.
  - Last pixel in cycle N+SIZE².
  - done in cycle N+SIZE²+1.
  - in_ready high again in cycle N+SIZE²+2.
- Throughput: one square per SIZE²+2 cycles.
- in_valid while in_ready=0: ignored and not queued. The upstream block must hold in_valid or wait for done.
- Input changes during DRAW have no effect on the square in progress, because coordinates and colour are latched.
- Colour 000 is drawn like any other colour (erase pass); no special casing.
- Reset mid-DRAW: immediately IDLE, out_plot=0, done is not pulsed. The partial square is left on screen.
- out_x/out_y/out_colour hold their last values when out_plot=0.

Decomposition:
- Shared package gets:
  - Colour constants: BLACK=000, RED=100, YELLOW=110, GREEN=010, BLUE=001.
  - Screen dimensions: 160, 120.
  - Lane y row: 112.
  - Square size: 4.
  - State encoding for square_plotter.
- One natural sub-module, square_offset_counter:
  - Nested dx/dy counter with enable, clear and last-pixel flag.
- The FSM and clip logic stay in square_plotter.

Test Plan:
- Basic square: reset, then request x=10, y=112, colour=100 → 16 plot pulses on consecutive cycles, (10..13,112..115) row-major, colour 100; done pulses in cycle 17 after the handshake; in_ready returns in cycle 18.
- Backpressure: hold in_valid with x=20, y=112 during an active square → no second latch until IDLE; the second square starts at (20,112) with exactly 16 pixels.
- Right-edge clip: x=158, y=50 → out_plot high only for x=158,159 (8 pulses); done still arrives at cycle 17.
- Bottom-edge clip: x=0, y=118 → plot only for rows 118,119 (8 pulses).
- Input change mid-draw: change in_colour from 110 to 000 during DRAW → all 16 pixels remain 110.
- Reset mid-square: assert reset at pixel 7 → out_plot=0 and in_ready=1 asynchronously, no done pulse; the next request draws a full square from dx=dy=0.

Source files
------------

// File: rtl/square_plotter_pkg.sv
// Shared constants and types for the square raster stage that feeds the VGA adapter.
package square_plotter_pkg;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK  = 3'b000;
  localparam colour_t RED    = 3'b100;
  localparam colour_t YELLOW = 3'b110;
  localparam colour_t GREEN  = 3'b010;
  localparam colour_t BLUE   = 3'b001;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int LANE_Y        = 112;
  localparam int SQUARE_SIZE   = 4;

  // Offset width covers the largest supported square edge (8).
  localparam int OFS_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } plot_state_e;

endpackage

// File: rtl/square_offset_counter.sv
// Row-major dx/dy walker over a SIZE x SIZE square with clear, enable and last-pixel flag.
module square_offset_counter
  import square_plotter_pkg::*;
#(
  parameter int SIZE = SQUARE_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [OFS_W-1:0] dx,
  output logic [OFS_W-1:0] dy,
  output logic             last
);

  localparam logic [OFS_W-1:0] MAX_OFS = OFS_W'(SIZE - 1);

  logic row_end;

  assign row_end = (dx == MAX_OFS);
  assign last    = row_end && (dy == MAX_OFS);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (enable) begin
      if (row_end) begin
        dx <= '0;
        dy <= dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_plotter.sv
// Expands one (x, y, colour) request into SIZE x SIZE clipped pixel writes, then pulses done.
module square_plotter
  import square_plotter_pkg::*;
#(
  parameter int SIZE     = SQUARE_SIZE,
  parameter int SCREEN_W = SCREEN_WIDTH,
  parameter int SCREEN_H = SCREEN_HEIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_colour,
  output logic       out_plot,
  output logic       busy,
  output logic       done
);

  plot_state_e      state_q, state_d;
  logic [7:0]       base_x;
  logic [6:0]       base_y;
  colour_t          base_colour;
  logic [OFS_W-1:0] dx, dy;
  logic             last_pixel;
  logic             accept;
  logic             step;
  logic [8:0]       sum_x;
  logic [7:0]       sum_y;

  assign accept = (state_q == ST_IDLE) && in_valid;

  square_offset_counter #(.SIZE(SIZE)) u_offsets (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (step),
    .dx     (dx),
    .dy     (dy),
    .last   (last_pixel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_x      <= '0;
      base_y      <= '0;
      base_colour <= BLACK;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_x      <= in_x;
        base_y      <= in_y;
        base_colour <= in_colour;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_DRAW;
      ST_DRAW: begin
        // The counter stops on the last pixel so the coordinates hold afterwards.
        step = !last_pixel;
        if (last_pixel) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sums are kept one bit wider so off-screen pixels are clipped, not wrapped.
  assign sum_x = {1'b0, base_x} + {{(9 - OFS_W){1'b0}}, dx};
  assign sum_y = {1'b0, base_y} + {{(8 - OFS_W){1'b0}}, dy};

  assign out_x      = sum_x[7:0];
  assign out_y      = sum_y[6:0];
  assign out_colour = base_colour;
  assign out_plot   = (state_q == ST_DRAW) && (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
  assign busy       = (state_q == ST_DRAW);
  assign done       = (state_q == ST_DONE);
  assign in_ready   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_square_plotter.sv
// Directed self-checking bench for square_plotter: full squares, clipping, backpressure, reset.
module tb_square_plotter;
  import square_plotter_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       out_plot;
  logic       busy;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  square_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .out_plot   (out_plot),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request while in_ready is high; the accepting edge happens inside.
  task automatic start(input int x, input int y, input logic [2:0] col);
    check("ready_before_request", 32'(in_ready), 1);
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = col;
    in_valid  = 1'b1;
    tick();
  endtask

  // Check all SIZE*SIZE pixel cycles, the done pulse and the return of in_ready.
  task automatic expect_square(input int x, input int y, input logic [2:0] col,
                               input bit keep_valid, input int exp_plots);
    int plots;
    plots = 0;
    if (!keep_valid) in_valid = 1'b0;
    for (int k = 0; k < SQUARE_SIZE * SQUARE_SIZE; k++) begin
      int  ex, ey;
      bit  vis;
      ex  = x + (k % SQUARE_SIZE);
      ey  = y + (k / SQUARE_SIZE);
      vis = (ex < SCREEN_WIDTH) && (ey < SCREEN_HEIGHT);
      check("pixel_plot", 32'(out_plot), 32'(vis));
      check("pixel_busy", 32'(busy), 1);
      check("pixel_ready", 32'(in_ready), 0);
      if (vis) begin
        check("pixel_x", 32'(out_x), 32'(ex));
        check("pixel_y", 32'(out_y), 32'(ey));
        check("pixel_colour", 32'(out_colour), 32'(col));
      end
      if (out_plot) plots++;
      tick();
    end
    check("plot_count", 32'(plots), 32'(exp_plots));
    check("done_pulse", 32'(done), 1);
    check("done_plot", 32'(out_plot), 0);
    check("done_busy", 32'(busy), 0);
    check("done_ready", 32'(in_ready), 0);
    tick();
    check("done_cleared", 32'(done), 0);
    check("ready_returned", 32'(in_ready), 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_colour = BLACK;
    tick();
    tick();

    check("reset_ready", 32'(in_ready), 1);
    check("reset_plot", 32'(out_plot), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_x", 32'(out_x), 0);
    check("reset_y", 32'(out_y), 0);
    check("reset_colour", 32'(out_colour), 0);

    #2 reset = 1'b0;
    tick();

    // Basic square on the lane row.
    start(10, LANE_Y, RED);
    expect_square(10, LANE_Y, RED, 1'b0, 16);

    // Backpressure: a held request must wait for IDLE, then draw fully.
    start(10, LANE_Y, RED);
    in_x      = 8'd20;
    in_y      = 7'(LANE_Y);
    in_colour = GREEN;
    expect_square(10, LANE_Y, RED, 1'b1, 16);
    tick();
    expect_square(20, LANE_Y, GREEN, 1'b0, 16);

    // Right-edge clip: only columns 158 and 159 are visible.
    start(158, 50, RED);
    expect_square(158, 50, RED, 1'b0, 8);

    // Bottom-edge clip: only rows 118 and 119 are visible.
    start(0, 118, GREEN);
    expect_square(0, 118, GREEN, 1'b0, 8);

    // Colour change during DRAW must not affect the latched colour.
    start(30, LANE_Y, YELLOW);
    in_colour = BLACK;
    in_x      = 8'd99;
    expect_square(30, LANE_Y, YELLOW, 1'b0, 16);

    // Erase pass draws like any other colour.
    start(30, LANE_Y, BLACK);
    expect_square(30, LANE_Y, BLACK, 1'b0, 16);

    // Reset at pixel 7: outputs drop asynchronously and no done follows.
    start(40, LANE_Y, BLUE);
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("mid_pixel7_x", 32'(out_x), 43);
    check("mid_pixel7_y", 32'(out_y), 32'(LANE_Y + 1));
    check("mid_pixel7_plot", 32'(out_plot), 1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_plot", 32'(out_plot), 0);
    check("async_reset_ready", 32'(in_ready), 1);
    check("async_reset_busy", 32'(busy), 0);
    check("async_reset_done", 32'(done), 0);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_done_after_reset", 32'(done), 0);
      check("idle_after_reset", 32'(in_ready), 1);
    end

    // The next request starts a full square from offset zero.
    start(50, LANE_Y, RED);
    expect_square(50, LANE_Y, RED, 1'b0, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
